// File: rtl/ir_nec_if.sv
// Handshake and output bundle for the NEC infrared transmitter.
// The master side requests frames. The slave side is the transmitter itself.
interface ir_nec_if;
    logic       start_i;
    logic       repeat_code_i;
    logic [7:0] addr_i;
    logic [7:0] cmd_i;
    logic       busy_o;
    logic       done_o;
    logic       ir_env_o;
    logic       ir_tx_o;

    modport master (
        output start_i, repeat_code_i, addr_i, cmd_i,
        input  busy_o, done_o, ir_env_o, ir_tx_o
    );

    modport slave (
        input  start_i, repeat_code_i, addr_i, cmd_i,
        output busy_o, done_o, ir_env_o, ir_tx_o
    );
endinterface

// File: rtl/ir_nec_transmitter.sv
// NEC infrared transmitter.
// It serialises a full 32-bit frame {~cmd, cmd, ~addr, addr}, LSB first, or a
// repeat code. It drives an unmodulated envelope and a carrier-gated LED output.
// Every state lasts a whole number of units, and each unit is UNIT_CYCLES clocks.
// Outputs come from registers, which are loaded from the next-state values.
module ir_nec_transmitter #(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_HALF = 658
) (
    input  logic    clk,
    input  logic    rst,
    ir_nec_if.slave bus
);
    localparam int UW = (UNIT_CYCLES  > 1) ? $clog2(UNIT_CYCLES)  : 1;
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CAR_LAST  = CW'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5
    } state_t;

    state_t        state_q,    state_d;
    logic [UW-1:0] unit_cnt_q, unit_cnt_d;
    logic [4:0]    units_q,    units_d;     // units remaining in the current state
    logic [4:0]    bit_idx_q,  bit_idx_d;
    logic [31:0]   frame_q,    frame_d;
    logic          rep_q,      rep_d;
    logic [CW-1:0] car_cnt_q,  car_cnt_d;
    logic          carrier_q,  carrier_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          env_q,      env_d;
    logic          tx_q,       tx_d;

    logic          unit_last_s;
    logic          state_end_s;
    logic          enter_mark_s;

    // Next-state logic for the frame sequencer, the carrier phase and the outputs.
    always_comb begin
        state_d    = state_q;
        units_d    = units_q;
        bit_idx_d  = bit_idx_q;
        frame_d    = frame_q;
        rep_d      = rep_q;
        done_d     = 1'b0;

        unit_last_s = (unit_cnt_q == UNIT_LAST);
        state_end_s = unit_last_s && (units_q == 5'd1);

        if (state_q == IDLE) begin
            unit_cnt_d = {UW{1'b0}};
        end else if (unit_last_s) begin
            unit_cnt_d = {UW{1'b0}};
        end else begin
            unit_cnt_d = unit_cnt_q + UW'(1);
        end

        if (state_q != IDLE && unit_last_s && !state_end_s) begin
            units_d = units_q - 5'd1;
        end else begin
            units_d = units_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    frame_d = {~bus.cmd_i, bus.cmd_i, ~bus.addr_i, bus.addr_i};
                    rep_d   = bus.repeat_code_i;
                    units_d = 5'd16;
                    state_d = LEAD_MARK;
                end else begin
                    state_d = IDLE;
                end
            end
            LEAD_MARK: begin
                if (state_end_s) begin
                    units_d = rep_q ? 5'd4 : 5'd8;
                    state_d = LEAD_SPACE;
                end else begin
                    state_d = LEAD_MARK;
                end
            end
            LEAD_SPACE: begin
                if (state_end_s) begin
                    units_d   = 5'd1;
                    bit_idx_d = 5'd0;
                    state_d   = rep_q ? STOP_MARK : BIT_MARK;
                end else begin
                    state_d = LEAD_SPACE;
                end
            end
            BIT_MARK: begin
                if (state_end_s) begin
                    units_d = frame_q[bit_idx_q] ? 5'd3 : 5'd1;
                    state_d = BIT_SPACE;
                end else begin
                    state_d = BIT_MARK;
                end
            end
            BIT_SPACE: begin
                if (state_end_s) begin
                    units_d = 5'd1;
                    if (bit_idx_q == 5'd31) begin
                        state_d = STOP_MARK;
                    end else begin
                        bit_idx_d = bit_idx_q + 5'd1;
                        state_d   = BIT_MARK;
                    end
                end else begin
                    state_d = BIT_SPACE;
                end
            end
            STOP_MARK: begin
                if (state_end_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = STOP_MARK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        env_d  = (state_d == LEAD_MARK) || (state_d == BIT_MARK) || (state_d == STOP_MARK);

        // Restart the carrier phase on entry to a mark so that each mark opens with a high half-period.
        enter_mark_s = env_d && (state_d != state_q);
        if (enter_mark_s) begin
            car_cnt_d = {CW{1'b0}};
            carrier_d = 1'b1;
        end else if (car_cnt_q == CAR_LAST) begin
            car_cnt_d = {CW{1'b0}};
            carrier_d = ~carrier_q;
        end else begin
            car_cnt_d = car_cnt_q + CW'(1);
            carrier_d = carrier_q;
        end

        tx_d = env_d & carrier_d;
    end

    // State, counter and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            unit_cnt_q <= {UW{1'b0}};
            units_q    <= 5'd0;
            bit_idx_q  <= 5'd0;
            frame_q    <= 32'd0;
            rep_q      <= 1'b0;
            car_cnt_q  <= {CW{1'b0}};
            carrier_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            env_q      <= 1'b0;
            tx_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            unit_cnt_q <= unit_cnt_d;
            units_q    <= units_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            rep_q      <= rep_d;
            car_cnt_q  <= car_cnt_d;
            carrier_q  <= carrier_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            env_q      <= env_d;
            tx_q       <= tx_d;
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.ir_env_o = env_q;
    assign bus.ir_tx_o  = tx_q;
endmodule
